// File: rtl/ocp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ocp_pkg
// Brief    : Shared OCP encodings (MCmd, SResp) and link FSM state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package ocp_pkg;

  localparam logic [2:0] c_MCMD_IDLE = 3'b000;
  localparam logic [2:0] c_MCMD_WR   = 3'b001;
  localparam logic [2:0] c_MCMD_RD   = 3'b010;

  localparam logic [1:0] c_SRESP_NULL = 2'b00;
  localparam logic [1:0] c_SRESP_DVA  = 2'b01;
  localparam logic [1:0] c_SRESP_FAIL = 2'b10;
  localparam logic [1:0] c_SRESP_ERR  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } ocp_state_e;

endpackage
`default_nettype wire

// File: rtl/ocp_master_fsm_if.sv
`default_nettype none
// ============================================================================
// Module   : ocp_master_fsm_if
// Brief    : Local request/response port plus basic OCP link of the master.
// Revision : 1.0 - initial release
// ============================================================================
interface ocp_master_fsm_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic                  rsp_timeout;
  logic [2:0]            MCmd;
  logic [ADDR_WIDTH-1:0] MAddr;
  logic [DATA_WIDTH-1:0] MData;
  logic                  SCmdAccept;
  logic [1:0]            SResp;
  logic [DATA_WIDTH-1:0] SData;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, SCmdAccept, SResp, SData,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, MCmd, MAddr, MData
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, SCmdAccept, SResp, SData,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, MCmd, MAddr, MData
  );
endinterface
`default_nettype wire

// File: rtl/ocp_timeout_ctr.sv
`default_nettype none
// ============================================================================
// Module   : ocp_timeout_ctr
// Brief    : Saturating wait counter; expired when it reaches TIMEOUT_CYCLES-1.
// Revision : 1.0 - initial release
// ============================================================================
module ocp_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int c_CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [c_CW-1:0] c_LAST = c_CW'(TIMEOUT_CYCLES - 1);

  logic [c_CW-1:0] r_count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable && (r_count != c_LAST)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign expired = (r_count == c_LAST);
endmodule
`default_nettype wire

// File: rtl/ocp_master_fsm.sv
`default_nettype none
// ============================================================================
// Module   : ocp_master_fsm
// Brief    : Single-outstanding OCP master; OCP_MASTER_TIMEOUT_EN adds abort.
// Revision : 1.0 - initial release
// ============================================================================
module ocp_master_fsm
  import ocp_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic               clock,
  input  logic               reset,
  ocp_master_fsm_if.master   bus
);
  ocp_state_e            r_state, w_state_nxt;
  logic                  r_write, w_write_nxt;
  logic                  r_req_ready, w_req_ready_nxt;
  logic                  r_rsp_valid, w_rsp_valid_nxt;
  logic [DATA_WIDTH-1:0] r_rsp_rdata, w_rsp_rdata_nxt;
  logic                  r_rsp_err, w_rsp_err_nxt;
  logic                  r_rsp_timeout, w_rsp_timeout_nxt;
  logic [2:0]            r_mcmd, w_mcmd_nxt;
  logic [ADDR_WIDTH-1:0] r_maddr, w_maddr_nxt;
  logic [DATA_WIDTH-1:0] r_mdata, w_mdata_nxt;
  logic                  w_expired;

  generate
    if (TIMEOUT_CYCLES < 2) begin : g_param_check
      $error("ocp_master_fsm: TIMEOUT_CYCLES must be at least 2");
    end
  endgenerate

`ifdef OCP_MASTER_TIMEOUT_EN
  logic w_ctr_clear, w_ctr_enable;
  // Holding clear through IDLE guarantees the count starts at zero in CMD.
  assign w_ctr_clear  = (r_state == ST_IDLE);
  assign w_ctr_enable = (r_state == ST_CMD) || (r_state == ST_RESP);

  ocp_timeout_ctr #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clock   (clock),
    .reset   (reset),
    .clear   (w_ctr_clear),
    .enable  (w_ctr_enable),
    .expired (w_expired)
  );
`else
  assign w_expired = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_write       <= 1'b0;
      r_req_ready   <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
      r_mcmd        <= c_MCMD_IDLE;
      r_maddr       <= '0;
      r_mdata       <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_write       <= w_write_nxt;
      r_req_ready   <= w_req_ready_nxt;
      r_rsp_valid   <= w_rsp_valid_nxt;
      r_rsp_rdata   <= w_rsp_rdata_nxt;
      r_rsp_err     <= w_rsp_err_nxt;
      r_rsp_timeout <= w_rsp_timeout_nxt;
      r_mcmd        <= w_mcmd_nxt;
      r_maddr       <= w_maddr_nxt;
      r_mdata       <= w_mdata_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_write_nxt       = r_write;
    w_rsp_rdata_nxt   = r_rsp_rdata;
    w_rsp_err_nxt     = r_rsp_err;
    w_rsp_timeout_nxt = r_rsp_timeout;
    w_mcmd_nxt        = r_mcmd;
    w_maddr_nxt       = r_maddr;
    w_mdata_nxt       = r_mdata;

    unique case (r_state)
      ST_IDLE: begin
        if (bus.req_valid && r_req_ready) begin
          w_state_nxt = ST_CMD;
          w_write_nxt = bus.req_write;
          w_mcmd_nxt  = bus.req_write ? c_MCMD_WR : c_MCMD_RD;
          w_maddr_nxt = bus.req_addr;
          w_mdata_nxt = bus.req_write ? bus.req_wdata : '0;
        end
      end
      ST_CMD: begin
        if (bus.SCmdAccept) begin
          w_mcmd_nxt  = c_MCMD_IDLE;
          w_maddr_nxt = '0;
          w_mdata_nxt = '0;
          // Response lines are only meaningful for reads.
          if (r_write) begin
            w_state_nxt       = ST_DONE;
            w_rsp_rdata_nxt   = '0;
            w_rsp_err_nxt     = 1'b0;
            w_rsp_timeout_nxt = 1'b0;
          end else if (bus.SResp != c_SRESP_NULL) begin
            w_state_nxt       = ST_DONE;
            w_rsp_rdata_nxt   = bus.SData;
            w_rsp_err_nxt     = (bus.SResp != c_SRESP_DVA);
            w_rsp_timeout_nxt = 1'b0;
          end else begin
            w_state_nxt = ST_RESP;
          end
        end else if (w_expired) begin
          w_state_nxt       = ST_DONE;
          w_mcmd_nxt        = c_MCMD_IDLE;
          w_maddr_nxt       = '0;
          w_mdata_nxt       = '0;
          w_rsp_rdata_nxt   = '0;
          w_rsp_err_nxt     = 1'b1;
          w_rsp_timeout_nxt = 1'b1;
        end
      end
      ST_RESP: begin
        if (bus.SResp != c_SRESP_NULL) begin
          w_state_nxt       = ST_DONE;
          w_rsp_rdata_nxt   = bus.SData;
          w_rsp_err_nxt     = (bus.SResp != c_SRESP_DVA);
          w_rsp_timeout_nxt = 1'b0;
        end else if (w_expired) begin
          w_state_nxt       = ST_DONE;
          w_rsp_rdata_nxt   = '0;
          w_rsp_err_nxt     = 1'b1;
          w_rsp_timeout_nxt = 1'b1;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // Registered view of the next state keeps both flags glitch-free.
    w_rsp_valid_nxt = (w_state_nxt == ST_DONE);
    w_req_ready_nxt = (w_state_nxt == ST_IDLE);
  end

  assign bus.req_ready   = r_req_ready;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_rdata   = r_rsp_rdata;
  assign bus.rsp_err     = r_rsp_err;
  assign bus.rsp_timeout = r_rsp_timeout;
  assign bus.MCmd        = r_mcmd;
  assign bus.MAddr       = r_maddr;
  assign bus.MData       = r_mdata;
endmodule
`default_nettype wire

// File: tb/tb_ocp_master_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_ocp_master_fsm
// Brief    : Directed self-checking bench for ocp_master_fsm (TIMEOUT_CYCLES=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ocp_master_fsm;
  logic clock;
  logic reset;
  int   n_total;
  int   n_pass;
  int   n_cmds;

  logic [2:0]  b2b_mcmd  [7];
  logic [31:0] b2b_maddr [7];
  logic [31:0] b2b_mdata [7];
  logic        b2b_rspv  [7];

  ocp_master_fsm_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  ocp_master_fsm #(
    .ADDR_WIDTH     (32),
    .DATA_WIDTH     (32),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.SCmdAccept = 1'b0;
    bus.SResp      = 2'b00;
    bus.SData      = '0;
  endtask

  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_total = 0;
    n_pass  = 0;
    reset   = 1'b0;
    clear_inputs();

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_err", bus.rsp_err, 0);
    check("rst_rsp_timeout", bus.rsp_timeout, 0);
    check("rst_mcmd", bus.MCmd, 3'b000);
    check("rst_maddr", bus.MAddr, 0);
    check("rst_mdata", bus.MData, 0);
    check("rst_rdata", bus.rsp_rdata, 0);
    reset = 1'b1;
    tick();
    check("ready_after_rst", bus.req_ready, 1);

    // Write with SCmdAccept tied high
    issue(1'b1, 32'h10, 32'hDEADBEEF);
    bus.SCmdAccept = 1'b1;
    tick();
    check("wr_mcmd", bus.MCmd, 3'b001);
    check("wr_maddr", bus.MAddr, 32'h10);
    check("wr_mdata", bus.MData, 32'hDEADBEEF);
    check("wr_ready_low", bus.req_ready, 0);
    check("wr_no_rsp_c1", bus.rsp_valid, 0);
    bus.req_valid = 1'b0;
    tick();
    check("wr_rsp_valid", bus.rsp_valid, 1);
    check("wr_rsp_err", bus.rsp_err, 0);
    check("wr_rdata_zero", bus.rsp_rdata, 0);
    check("wr_mcmd_idle", bus.MCmd, 3'b000);
    check("wr_mdata_zero", bus.MData, 0);
    tick();
    check("wr_rsp_pulse", bus.rsp_valid, 0);
    check("wr_ready_back", bus.req_ready, 1);
    bus.SCmdAccept = 1'b0;

    // Read with delayed accept and delayed DVA
    issue(1'b0, 32'h20, 32'hFFFFFFFF);
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 1) begin
        bus.req_valid = 1'b0;
        check("rd_mdata_zero", bus.MData, 0);
      end
      check("rd_stall_mcmd", bus.MCmd, 3'b010);
      check("rd_stall_maddr", bus.MAddr, 32'h20);
    end
    bus.SCmdAccept = 1'b1;
    tick();
    bus.SCmdAccept = 1'b0;
    check("rd_resp_mcmd", bus.MCmd, 3'b000);
    check("rd_resp_maddr", bus.MAddr, 0);
    check("rd_resp_norsp", bus.rsp_valid, 0);
    tick();
    check("rd_wait_norsp", bus.rsp_valid, 0);
    bus.SResp = 2'b01;
    bus.SData = 32'h12345678;
    tick();
    bus.SResp = 2'b00;
    check("rd_rsp_valid", bus.rsp_valid, 1);
    check("rd_rdata", bus.rsp_rdata, 32'h12345678);
    check("rd_err", bus.rsp_err, 0);
    tick();
    check("rd_rsp_pulse", bus.rsp_valid, 0);

    // Read answered with ERR
    issue(1'b0, 32'h30, 32'h0);
    tick();
    bus.req_valid  = 1'b0;
    bus.SCmdAccept = 1'b1;
    tick();
    bus.SCmdAccept = 1'b0;
    bus.SResp      = 2'b11;
    bus.SData      = 32'hBAD0BAD0;
    tick();
    bus.SResp = 2'b00;
    check("err_rsp_valid", bus.rsp_valid, 1);
    check("err_rsp_err", bus.rsp_err, 1);
    check("err_rdata", bus.rsp_rdata, 32'hBAD0BAD0);
    tick();

    // Read with DVA on the accept cycle
    issue(1'b0, 32'h40, 32'h0);
    tick();
    bus.req_valid  = 1'b0;
    bus.SCmdAccept = 1'b1;
    bus.SResp      = 2'b01;
    bus.SData      = 32'h55AA1234;
    tick();
    clear_inputs();
    check("same_rsp_valid", bus.rsp_valid, 1);
    check("same_rsp_err", bus.rsp_err, 0);
    check("same_rdata", bus.rsp_rdata, 32'h55AA1234);
    tick();

    // Write with a stray FAIL response, which must be ignored
    issue(1'b1, 32'h50, 32'h1);
    tick();
    bus.req_valid  = 1'b0;
    bus.SCmdAccept = 1'b1;
    bus.SResp      = 2'b10;
    tick();
    clear_inputs();
    check("wrfail_rsp_valid", bus.rsp_valid, 1);
    check("wrfail_err", bus.rsp_err, 0);
    tick();

    // Reset asserted during CMD
    issue(1'b0, 32'h58, 32'h0);
    tick();
    bus.req_valid = 1'b0;
    check("rstcmd_mcmd_pre", bus.MCmd, 3'b010);
    reset = 1'b0;
    #1;
    check("rstcmd_mcmd", bus.MCmd, 3'b000);
    check("rstcmd_maddr", bus.MAddr, 0);
    tick();
    reset = 1'b1;
    tick();

    // Reset asserted during RESP
    issue(1'b0, 32'h60, 32'h0);
    tick();
    bus.req_valid  = 1'b0;
    bus.SCmdAccept = 1'b1;
    tick();
    bus.SCmdAccept = 1'b0;
    bus.SResp      = 2'b01;
    bus.SData      = 32'h99;
    reset          = 1'b0;
    #1;
    check("rstresp_mcmd", bus.MCmd, 3'b000);
    check("rstresp_ready", bus.req_ready, 0);
    check("rstresp_rspv", bus.rsp_valid, 0);
    tick();
    check("rstresp_rspv_hold", bus.rsp_valid, 0);
    reset = 1'b1;
    clear_inputs();
    tick();
    check("rstresp_ready_after", bus.req_ready, 1);
    check("rstresp_no_rsp", bus.rsp_valid, 0);
    tick();
    check("rstresp_no_rsp2", bus.rsp_valid, 0);

`ifdef OCP_MASTER_TIMEOUT_EN
    // Timeout abort after 8 cycles in CMD
    issue(1'b0, 32'h70, 32'h0);
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c == 1) bus.req_valid = 1'b0;
      check("to_mcmd_held", bus.MCmd, 3'b010);
      check("to_no_rsp", bus.rsp_valid, 0);
    end
    tick();
    check("to_rsp_valid", bus.rsp_valid, 1);
    check("to_rsp_err", bus.rsp_err, 1);
    check("to_rsp_timeout", bus.rsp_timeout, 1);
    check("to_rdata", bus.rsp_rdata, 0);
    check("to_mcmd", bus.MCmd, 3'b000);
    tick();

    // Accept on the expiry cycle wins over the timeout
    issue(1'b1, 32'h74, 32'hA5);
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c == 1) bus.req_valid = 1'b0;
      check("topri_mcmd", bus.MCmd, 3'b001);
    end
    bus.SCmdAccept = 1'b1;
    tick();
    bus.SCmdAccept = 1'b0;
    check("topri_rsp_valid", bus.rsp_valid, 1);
    check("topri_err", bus.rsp_err, 0);
    check("topri_timeout", bus.rsp_timeout, 0);
    tick();
`else
    // Without the timeout the command is held indefinitely
    issue(1'b0, 32'h70, 32'h0);
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (c == 1) bus.req_valid = 1'b0;
    end
    check("nto_mcmd_held", bus.MCmd, 3'b010);
    check("nto_maddr_held", bus.MAddr, 32'h70);
    check("nto_no_rsp", bus.rsp_valid, 0);
    bus.SCmdAccept = 1'b1;
    bus.SResp      = 2'b01;
    bus.SData      = 32'h0F0F0F0F;
    tick();
    clear_inputs();
    check("nto_rsp_valid", bus.rsp_valid, 1);
    check("nto_timeout", bus.rsp_timeout, 0);
    check("nto_rdata", bus.rsp_rdata, 32'h0F0F0F0F);
    tick();
`endif

    // Back-to-back writes with req_valid held high
    b2b_mcmd  = '{3'b001, 3'b000, 3'b000, 3'b001, 3'b000, 3'b000, 3'b000};
    b2b_maddr = '{32'h100, 32'h0, 32'h0, 32'h104, 32'h0, 32'h0, 32'h0};
    b2b_mdata = '{32'h11, 32'h0, 32'h0, 32'h22, 32'h0, 32'h0, 32'h0};
    b2b_rspv  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    n_cmds = 0;
    bus.SCmdAccept = 1'b1;
    issue(1'b1, 32'h100, 32'h11);
    for (int c = 0; c < 7; c++) begin
      tick();
      if (bus.MCmd != 3'b000) n_cmds++;
      check("b2b_mcmd", bus.MCmd, b2b_mcmd[c]);
      check("b2b_maddr", bus.MAddr, b2b_maddr[c]);
      check("b2b_mdata", bus.MData, b2b_mdata[c]);
      check("b2b_rsp_valid", bus.rsp_valid, b2b_rspv[c]);
      if (c == 0) begin
        bus.req_addr  = 32'h104;
        bus.req_wdata = 32'h22;
      end
      if (c == 3) bus.req_valid = 1'b0;
    end
    check("b2b_cmd_count", n_cmds, 2);
    clear_inputs();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire
